// File: rtl/fetch_pkg.sv
// Shared widths and types for the instruction fetch controller and its buffer.
package fetch_pkg;

  localparam int PC_W        = 64;
  localparam int INSTR_MAX_W = 64;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_t;

  // Buffer entries carry the widest supported word; narrower words are zero-extended.
  typedef struct packed {
    logic [INSTR_MAX_W-1:0] instr;
    logic [PC_W-1:0]        pc;
  } fetch_entry_t;

  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus: instruction memory port, redirect input and consumer handshake.
interface fetch_ctrl_if #(
  parameter int N = 32
) ();

  logic [5:0]                   imem_addr;
  logic [N-1:0]                 imem_q;
  logic                         br_taken;
  logic [fetch_pkg::PC_W-1:0]   br_target;
  logic [N-1:0]                 instr;
  logic [fetch_pkg::PC_W-1:0]   instr_pc;
  logic                         instr_valid;
  logic                         instr_ready;
  logic                         halted;
  logic [15:0]                  delivered;

  modport master (
    output imem_addr, instr, instr_pc, instr_valid, halted, delivered,
    input  imem_q, br_taken, br_target, instr_ready
  );

  modport slave (
    input  imem_addr, instr, instr_pc, instr_valid, halted, delivered,
    output imem_q, br_taken, br_target, instr_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small circular instruction buffer with same-cycle push/pop and a synchronous flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output fetch_entry_t     head
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  // An empty buffer presents zeros so stale storage never leaks to the outputs.
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: sequential fetch into a small buffer, halt on a zero word,
// redirect on branch, and a saturating count of instructions handed to the consumer.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = 2
) (
  input logic          clk,
  input logic          reset,
  fetch_ctrl_if.master bus
);

  localparam int CNT_W = ((DEPTH > 1) ? $clog2(DEPTH) : 1) + 1;

  fetch_state_t     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [15:0]      delivered_q, delivered_d;
  logic             push, pop, full, empty, word_zero;
  logic [CNT_W-1:0] count;
  fetch_entry_t     push_data, head;
  logic             unused_bits;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign word_zero = (bus.imem_q == '0);
  assign pop       = bus.instr_valid && bus.instr_ready;
  // A full buffer still accepts a word when its head leaves in the same cycle.
  assign push      = (state_q == FETCH) && !bus.br_taken && !word_zero && (!full || pop);
  assign push_data = '{instr: INSTR_MAX_W'(bus.imem_q), pc: pc_q};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    delivered_d = delivered_q;
    if (pop) delivered_d = sat_inc(delivered_q);
    if (bus.br_taken) begin
      state_d = FETCH;
      pc_d    = word_align(bus.br_target);
    end else if (state_q == FETCH) begin
      if (word_zero)  state_d = HALT;
      else if (push)  pc_d    = pc_q + PC_W'(4);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= FETCH;
      pc_q        <= '0;
      delivered_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      delivered_q <= delivered_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (bus.br_taken),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .head      (head)
  );

  assign bus.imem_addr   = pc_q[7:2];
  assign bus.instr       = head.instr[N-1:0];
  assign bus.instr_pc    = head.pc;
  assign bus.instr_valid = !empty;
  assign bus.halted      = (state_q == HALT);
  assign bus.delivered   = delivered_q;

  // Occupancy is kept for observability; target low bits are ignored by design.
  assign unused_bits = ^{count, head.instr, bus.br_target[1:0]};

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized traffic against a queue-based model.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam int N     = 32;
  localparam int DEPTH = 2;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] mem [64];
  int           checks = 0;
  int           errors = 0;

  typedef struct {
    logic [N-1:0] instr;
    logic [63:0]  pc;
  } ent_t;
  ent_t        mq [$];
  logic [63:0] m_pc;
  bit          m_halt;
  int          m_deliv;

  fetch_ctrl_if #(.N(N)) bus ();
  fetch_ctrl #(.N(N), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  assign bus.imem_q = mem[bus.imem_addr];

  // Reference: consumer takes the oldest entry, redirect empties the buffer, a zero word stops fetch.
  task automatic model_edge();
    logic [N-1:0] w;
    if (mq.size() > 0 && bus.instr_ready) begin
      void'(mq.pop_front());
      if (m_deliv < 65535) m_deliv++;
    end
    if (bus.br_taken) begin
      mq.delete();
      m_pc   = {bus.br_target[63:2], 2'b00};
      m_halt = 1'b0;
    end else if (!m_halt) begin
      w = mem[m_pc[7:2]];
      if (w == '0) m_halt = 1'b1;
      else if (mq.size() < DEPTH) begin
        mq.push_back('{instr: w, pc: m_pc});
        m_pc = m_pc + 64'd4;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset           = 1'b0;
    bus.instr_ready = 1'b0;
    bus.br_taken    = 1'b0;
    bus.br_target   = '0;
    repeat (2) @(posedge clk);
    #1;
    mq.delete();
    m_pc    = '0;
    m_halt  = 1'b0;
    m_deliv = 0;
    reset   = 1'b1;
  endtask

  task automatic fill_mem(input int zero_at);
    for (int i = 0; i < 64; i++) mem[i] = (i == zero_at) ? '0 : (32'hC000_0000 + 32'(i));
  endtask

  task automatic test_reset();
    fill_mem(-1);
    reset           = 1'b0;
    bus.instr_ready = 1'b0;
    bus.br_taken    = 1'b0;
    bus.br_target   = '0;
    @(posedge clk);
    #1;
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", bus.instr_valid); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b expected 0", bus.halted); end
    checks++; if (bus.delivered !== 16'd0) begin errors++; $display("FAIL rst_delivered: got %0d expected 0", bus.delivered); end
    checks++; if (bus.instr !== '0) begin errors++; $display("FAIL rst_instr: got %h expected 0", bus.instr); end
    checks++; if (bus.instr_pc !== 64'd0) begin errors++; $display("FAIL rst_instr_pc: got %h expected 0", bus.instr_pc); end
    checks++; if (bus.imem_addr !== 6'd0) begin errors++; $display("FAIL rst_imem_addr: got %0d expected 0", bus.imem_addr); end
    mq.delete(); m_pc = '0; m_halt = 1'b0; m_deliv = 0;
    reset = 1'b1;
    tick();
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 64'd0 || bus.instr !== mem[0])
      begin errors++; $display("FAIL first_fetch: got v=%b pc=%h i=%h expected v=1 pc=0 i=%h", bus.instr_valid, bus.instr_pc, bus.instr, mem[0]); end
    checks++; if (bus.imem_addr !== 6'd1) begin errors++; $display("FAIL first_fetch_addr: got %0d expected 1", bus.imem_addr); end
  endtask

  task automatic test_halt_seq();
    logic [63:0]  seen_pc [$];
    logic [N-1:0] seen_i  [$];
    fill_mem(13);
    apply_reset();
    bus.instr_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bus.instr_valid) begin
        seen_pc.push_back(bus.instr_pc);
        seen_i.push_back(bus.instr);
      end
    end
    checks++; if (seen_pc.size() != 13) begin errors++; $display("FAIL halt_seq_len: got %0d expected 13", seen_pc.size()); end
    for (int i = 0; i < seen_pc.size() && i < 13; i++) begin
      checks++; if (seen_pc[i] !== 64'(4 * i) || seen_i[i] !== mem[i])
        begin errors++; $display("FAIL halt_seq_%0d: got pc=%h i=%h expected pc=%h i=%h", i, seen_pc[i], seen_i[i], 4 * i, mem[i]); end
    end
    checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_seq_halted: got %b expected 1", bus.halted); end
    checks++; if (bus.delivered !== 16'd13) begin errors++; $display("FAIL halt_seq_delivered: got %0d expected 13", bus.delivered); end
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL halt_seq_drained: got %b expected 0", bus.instr_valid); end
  endtask

  task automatic test_backpressure();
    fill_mem(-1);
    apply_reset();
    repeat (10) tick();
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 64'h0) begin errors++; $display("FAIL bp_head: got v=%b pc=%h expected v=1 pc=0", bus.instr_valid, bus.instr_pc); end
    checks++; if (bus.imem_addr !== 6'd2) begin errors++; $display("FAIL bp_fetch_pc: got addr %0d expected 2", bus.imem_addr); end
    checks++; if (dut.u_fifo.count_q !== 2'd2) begin errors++; $display("FAIL bp_count: got %0d expected 2", dut.u_fifo.count_q); end
    checks++; if (bus.delivered !== 16'd0) begin errors++; $display("FAIL bp_delivered: got %0d expected 0", bus.delivered); end
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 64'(4 * i))
        begin errors++; $display("FAIL bp_deliver_%0d: got v=%b pc=%h expected v=1 pc=%h", i, bus.instr_valid, bus.instr_pc, 4 * i); end
      tick();
      if (i == 0) begin
        checks++; if (dut.u_fifo.count_q !== 2'd2) begin errors++; $display("FAIL full_pop_push_count: got %0d expected 2", dut.u_fifo.count_q); end
        checks++; if (bus.delivered !== 16'd1 || bus.instr_pc !== 64'h4 || bus.imem_addr !== 6'd3)
          begin errors++; $display("FAIL full_pop_push: got d=%0d pc=%h addr=%0d expected d=1 pc=4 addr=3", bus.delivered, bus.instr_pc, bus.imem_addr); end
      end
    end
  endtask

  task automatic test_redirect();
    fill_mem(-1);
    apply_reset();
    repeat (4) tick();
    checks++; if (dut.u_fifo.count_q !== 2'd2) begin errors++; $display("FAIL br_pre_count: got %0d expected 2", dut.u_fifo.count_q); end
    bus.br_taken    = 1'b1;
    bus.br_target   = 64'h23;
    bus.instr_ready = 1'b1;
    tick();
    bus.br_taken    = 1'b0;
    bus.instr_ready = 1'b0;
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL br_flush: got v=%b expected 0", bus.instr_valid); end
    checks++; if (bus.delivered !== 16'd1) begin errors++; $display("FAIL br_pop_counted: got %0d expected 1", bus.delivered); end
    checks++; if (bus.imem_addr !== 6'd8) begin errors++; $display("FAIL br_target_addr: got %0d expected 8", bus.imem_addr); end
    tick();
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 64'h20 || bus.instr !== mem[8])
      begin errors++; $display("FAIL br_first: got v=%b pc=%h i=%h expected v=1 pc=20 i=%h", bus.instr_valid, bus.instr_pc, bus.instr, mem[8]); end
  endtask

  task automatic test_halt_redirect();
    int guard = 0;
    fill_mem(3);
    apply_reset();
    bus.instr_ready = 1'b1;
    while (bus.halted !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL hr_halt: got %b expected 1 within 20 cycles", bus.halted); end
    bus.br_taken  = 1'b1;
    bus.br_target = 64'h0;
    tick();
    bus.br_taken  = 1'b0;
    checks++; if (bus.halted !== 1'b0 || bus.imem_addr !== 6'd0)
      begin errors++; $display("FAIL hr_resume: got halted=%b addr=%0d expected halted=0 addr=0", bus.halted, bus.imem_addr); end
    tick();
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 64'h0)
      begin errors++; $display("FAIL hr_first: got v=%b pc=%h expected v=1 pc=0", bus.instr_valid, bus.instr_pc); end
  endtask

  task automatic test_wrap();
    logic [63:0] prev = '1;
    bit found = 1'b0;
    fill_mem(-1);
    apply_reset();
    bus.instr_ready = 1'b1;
    for (int c = 0; c < 80 && !found; c++) begin
      tick();
      if (bus.instr_valid) begin
        if (bus.instr_pc == 64'hFC) begin
          checks++; if (bus.imem_addr !== 6'd0) begin errors++; $display("FAIL wrap_addr: got %0d expected 0", bus.imem_addr); end
        end
        if (prev == 64'hFC) begin
          found = 1'b1;
          checks++; if (bus.instr_pc !== 64'h100 || bus.instr !== mem[0])
            begin errors++; $display("FAIL wrap_next: got pc=%h i=%h expected pc=100 i=%h", bus.instr_pc, bus.instr, mem[0]); end
        end
        prev = bus.instr_pc;
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL wrap_seen: got no 0xFC->0x100 step expected one within 80 cycles"); end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    fill_mem(-1);
    apply_reset();
    bus.instr_ready = 1'b1;
    repeat (6) tick();
    bus.instr_ready = 1'b0;
    tick();
    checks++; if (bus.delivered !== 16'd5 || dut.u_fifo.count_q !== 2'd2)
      begin errors++; $display("FAIL rm_pre: got d=%0d cnt=%0d expected d=5 cnt=2", bus.delivered, dut.u_fifo.count_q); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.instr_valid !== 1'b0 || bus.halted !== 1'b0 || bus.delivered !== 16'd0)
      begin errors++; $display("FAIL rm_ctrl: got v=%b h=%b d=%0d expected 0 0 0", bus.instr_valid, bus.halted, bus.delivered); end
    checks++; if (bus.instr !== '0 || bus.instr_pc !== 64'd0 || bus.imem_addr !== 6'd0)
      begin errors++; $display("FAIL rm_data: got i=%h pc=%h addr=%0d expected 0 0 0", bus.instr, bus.instr_pc, bus.imem_addr); end
    @(posedge clk);
    #1;
    mq.delete(); m_pc = '0; m_halt = 1'b0; m_deliv = 0;
    reset = 1'b1;
    bus.instr_ready = 1'b1;
    while (bus.instr_valid !== 1'b1 && guard < 5) begin
      tick();
      guard++;
    end
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 64'h0)
      begin errors++; $display("FAIL rm_first: got v=%b pc=%h expected v=1 pc=0", bus.instr_valid, bus.instr_pc); end
  endtask

  task automatic test_random();
    for (int run = 0; run < 4; run++) begin
      for (int i = 0; i < 64; i++) mem[i] = ($urandom_range(0, 15) == 0) ? '0 : ($urandom() | 32'h1);
      apply_reset();
      for (int c = 0; c < 300; c++) begin
        bus.instr_ready = ($urandom_range(0, 9) < 7);
        bus.br_taken    = ($urandom_range(0, 19) == 0);
        bus.br_target   = {$urandom(), $urandom()};
        if (run == 3 && c == 0) begin
          bus.br_taken  = 1'b1;
          bus.br_target = 64'hFFFF_FFFF_FFFF_FFF1;
        end
        tick();
        checks++; if (bus.instr_valid !== (mq.size() > 0))
          begin errors++; $display("FAIL rnd_valid r%0d c%0d: got %b expected %b", run, c, bus.instr_valid, mq.size() > 0); end
        checks++; if (bus.halted !== m_halt)
          begin errors++; $display("FAIL rnd_halted r%0d c%0d: got %b expected %b", run, c, bus.halted, m_halt); end
        checks++; if (bus.delivered !== 16'(m_deliv))
          begin errors++; $display("FAIL rnd_delivered r%0d c%0d: got %0d expected %0d", run, c, bus.delivered, m_deliv); end
        checks++; if (bus.imem_addr !== m_pc[7:2])
          begin errors++; $display("FAIL rnd_addr r%0d c%0d: got %0d expected %0d", run, c, bus.imem_addr, m_pc[7:2]); end
        if (mq.size() > 0) begin
          checks++; if (bus.instr_pc !== mq[0].pc || bus.instr !== mq[0].instr)
            begin errors++; $display("FAIL rnd_head r%0d c%0d: got pc=%h i=%h expected pc=%h i=%h", run, c, bus.instr_pc, bus.instr, mq[0].pc, mq[0].instr); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_halt_seq();
    test_backpressure();
    test_redirect();
    test_halt_redirect();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1);
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter N, default 32, instruction word width in bits.
REQ-002 Parameter DEPTH, default 2, number of entries in the instruction buffer (power of two, 2..4).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 imem_addr  output  6  word address to instruction memory; equals fetch_pc[7:2].
REQ-006 imem_q  input  N  instruction word, valid combinationally in the same cycle as imem_addr.
REQ-007 br_taken  input  1  single-cycle redirect request.
REQ-008 br_target  input  64  redirect byte address; bits [1:0] ignored and treated as 0.
REQ-009 instr  output  N  instruction at buffer head.
REQ-010 instr_pc  output  64  byte address of instr.
REQ-011 instr_valid  output  1  buffer head holds a valid entry.
REQ-012 instr_ready  input  1  consumer accepts head this cycle.
REQ-013 halted  output  1  fetch stopped on an all-zero word.
REQ-014 delivered  output  16  count of instructions accepted by consumer.

Function
REQ-015 FSM states: FETCH and HALT; reset state FETCH.
REQ-016 In FETCH, a push of {imem_q, fetch_pc} occurs when imem_q != 0 and (count < DEPTH or a pop occurs this cycle); fetch_pc then advances by 4.
REQ-017 In FETCH, when imem_q == 0 and no redirect, no push occurs, fetch_pc holds, and state moves to HALT next cycle.
REQ-018 In HALT, no push occurs and fetch_pc holds; buffered entries continue to drain.
REQ-019 halted is 1 exactly when state is HALT.
REQ-020 A pop occurs when instr_valid and instr_ready are both 1; instr, instr_pc and instr_valid are driven from registered buffer state only.
REQ-021 Push-to-visible latency is one cycle: a word pushed at edge k appears at the buffer head after edge k if the buffer was empty.
REQ-022 When the buffer is full and a pop occurs, a push in the same cycle is accepted; count is unchanged.
REQ-023 When br_taken is 1: buffer is flushed (count 0), fetch_pc loads {br_target[63:2], 2'b00}, state becomes FETCH, no push occurs that cycle; the pop is still counted in delivered if instr_valid and instr_ready are 1.
REQ-024 A redirect takes precedence over push, halt detection and HALT state.
REQ-025 fetch_pc is a 64-bit register incrementing modulo 2^64; imem_addr wraps from 63 to 0 with no special action.
REQ-026 delivered increments by 1 on each pop and saturates at 16'hFFFF.
REQ-027 Buffer read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.

Reset
REQ-028 While reset is 0: fetch_pc = 0, state = FETCH, count = 0, pointers = 0, delivered = 0, instr_valid = 0, halted = 0.
REQ-029 instr and instr_pc read 0 during reset; buffer storage contents need not be cleared.
REQ-030 Reset asserted mid-operation discards all buffered entries immediately, with no pop counted.
REQ-031 First fetch occurs on the first rising clk edge after reset deasserts, reading imem_addr 0.

Structure
REQ-032 Package fetch_pkg holds PC_W = 64, the fetch_state_t enum (FETCH, HALT) and the fetch_entry_t struct {instr, pc}.
REQ-033 The buffer is implemented as sub-module fetch_fifo with push, pop, flush, full, empty and count ports, parameterized by DEPTH.

Verification
REQ-034 Memory words 0..12 are nonzero and word 13 is 0, with instr_ready held 1: instr_pc sequence 0x0,0x4,...,0x30, then halted = 1 and delivered = 13.
REQ-035 instr_ready held 0 for 10 cycles from reset: count saturates at 2 with heads at instr_pc 0x0 then 0x4 and fetch_pc = 0x8; after instr_ready rises, 0x0, 0x4, 0x8 are delivered on consecutive cycles.
REQ-036 Buffer full and instr_ready = 1 for one cycle: one pop and one push occur in that cycle, and count stays 2.
REQ-037 br_taken = 1 with br_target = 0x23 while the buffer holds 2 entries: the buffer is flushed, and the next valid instr_pc is 0x20 with instr = memory word 8.
REQ-038 Redirect issued while in HALT with br_target = 0x0: halted drops the next cycle and fetch restarts at instr_pc 0x0; a separate run with all memory words nonzero shows imem_addr wrapping 63 -> 0 with instr_pc 0xFC followed by 0x100.
REQ-039 reset asserted for 1 cycle while count = 2 and delivered = 5: all outputs are at reset values immediately, and after release the first delivered instr_pc is 0x0.
